// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the single-cycle core: word RAM with zero-latency reads,
// plus an MMIO window with STATUS, TXDATA (buffered by a TX FIFO), CYCLE and CTRL.
module dmem_mmio_responder #(
   parameter int          RAM_WORDS  = 64,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'h0FC0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready
);

   localparam int          RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int          PW        = $clog2(FIFO_DEPTH);
   localparam int          CW        = $clog2(FIFO_DEPTH + 1);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_TXDATA = 2'd1;
   localparam logic [1:0] REG_CYCLE  = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   // Storage without reset: contents are undefined until written.
   logic [31:0] ram_q  [RAM_WORDS];
   logic [31:0] fifo_q [FIFO_DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [31:0]   cycle_q, cycle_d;
   logic          out_valid_q, out_valid_d;
   logic [31:0]   out_data_q, out_data_d;

   logic              ram_hit, mmio_hit;
   logic [1:0]        reg_sel;
   logic [RAM_AW-1:0] ram_idx;
   logic              ram_we, push, ctrl_clr;
   logic              pop, full, empty, push_ok, overflow, head_from_wd;
   logic [31:0]       status_word;

   assign ram_hit  = (a < RAM_BYTES);
   assign mmio_hit = (a[31:4] == MMIO_BASE[31:4]);
   assign reg_sel  = a[3:2];
   assign ram_idx  = a[RAM_AW+1:2];

   assign ram_we   = we & ram_hit;
   assign push     = we & ~ram_hit & mmio_hit & (reg_sel == REG_TXDATA);
   assign ctrl_clr = we & ~ram_hit & mmio_hit & (reg_sel == REG_CTRL) & wd[0];

   assign full        = (count_q == DEPTH_C);
   assign empty       = (count_q == '0);
   assign status_word = {ovf_q, 21'b0, full, empty, 8'(count_q)};

   always_comb begin
      pop      = out_valid_q & out_ready;
      push_ok  = push & (~full | pop);
      overflow = push & full & ~pop;
      // The incoming word becomes the head only if nothing remains after this cycle's pop.
      head_from_wd = push_ok & (count_q == CW'(pop));

      wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      out_valid_d = (count_d != '0);
      out_data_d  = '0;
      if (count_d != '0) begin
         out_data_d = head_from_wd ? wd : fifo_q[rd_ptr_d];
      end

      // An overflowing push outranks a simultaneous clear.
      ovf_d = ovf_q;
      if (overflow) begin
         ovf_d = 1'b1;
      end else if (ctrl_clr) begin
         ovf_d = 1'b0;
      end

      cycle_d = cycle_q + 32'd1;
   end

   always_comb begin
      rd = '0;
      if (ram_hit) begin
         rd = ram_q[ram_idx];
      end else if (mmio_hit) begin
         case (reg_sel)
            REG_STATUS: rd = status_word;
            REG_CYCLE:  rd = cycle_q;
            default:    rd = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_idx] <= wd;
      end
      if (push_ok) begin
         fifo_q[wr_ptr_q] <= wd;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         cycle_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         cycle_q     <= cycle_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Randomized and directed checks of dmem_mmio_responder against a queue/array reference model.
module tb_dmem_mmio_responder;

   localparam logic [31:0] STATUS_A = 32'h0000_0FC0;
   localparam logic [31:0] TX_A     = 32'h0000_0FC4;
   localparam logic [31:0] CYC_A    = 32'h0000_0FC8;
   localparam logic [31:0] CTRL_A   = 32'h0000_0FCC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        we = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] wd = '0;
   logic        out_ready = 1'b0;
   logic [31:0] rd;
   logic        out_valid;
   logic [31:0] out_data;

   int n_checks = 0;
   int n_errors = 0;
   int n_txn    = 0;

   logic [31:0] m_ram [64];
   bit          m_ram_ok [64];
   logic [31:0] m_fifo [$];
   bit          m_ovf;
   logic [31:0] m_cycle;

   dmem_mmio_responder dut (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .a         (a),
      .wd        (wd),
      .rd        (rd),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_status();
      int n;
      n = m_fifo.size();
      return {m_ovf, 21'b0, (n == 8), (n == 0), 8'(n)};
   endfunction

   // Expected load value; returns 0 when the RAM word has never been written.
   function automatic bit m_read(input logic [31:0] addr, output logic [31:0] val);
      val = '0;
      if (addr < 32'd256) begin
         val = m_ram[addr[7:2]];
         return m_ram_ok[addr[7:2]];
      end
      if (addr[31:4] == 28'h0FC) begin
         case (addr[3:2])
            2'd0:    val = m_status();
            2'd2:    val = m_cycle;
            default: val = '0;
         endcase
      end
      return 1'b1;
   endfunction

   // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
   task automatic step(input logic w, input logic [31:0] ad, input logic [31:0] d, input logic r);
      logic [31:0] exp_rd;
      bit          known;
      bit          pop;
      bit          push;
      we = w; a = ad; wd = d; out_ready = r;
      #3;
      check_eq("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
      check_eq("out_data", out_data, (m_fifo.size() != 0) ? m_fifo[0] : 32'h0);
      known = m_read(ad, exp_rd);
      if (known) check_eq("rd", rd, exp_rd);
      n_txn++;
      $display("txn %0d we=%0b a=%h wd=%h rdy=%0b rd=%h ov=%0b od=%h",
               n_txn, w, ad, d, r, rd, out_valid, out_data);
      @(posedge clk);
      pop  = (m_fifo.size() != 0) && (r == 1'b1);
      push = w && (ad[31:2] == 30'h3F1);
      if (w && ad < 32'd256) begin
         m_ram[ad[7:2]]    = d;
         m_ram_ok[ad[7:2]] = 1'b1;
      end
      if (w && ad[31:2] == 30'h3F3 && d[0]) m_ovf = 1'b0;
      if (pop) void'(m_fifo.pop_front());
      if (push) begin
         if (m_fifo.size() == 8) m_ovf = 1'b1;
         else m_fifo.push_back(d);
      end
      m_cycle = m_cycle + 32'd1;
      #1;
   endtask

   function automatic logic [31:0] rand_addr();
      int          k;
      logic [31:0] lo;
      k  = $urandom_range(0, 99);
      lo = 32'($urandom_range(0, 3));
      if (k < 30) return TX_A + lo;
      if (k < 55) return 32'($urandom_range(0, 63)) * 32'd4 + lo;
      if (k < 65) return STATUS_A + lo;
      if (k < 75) return CYC_A + lo;
      if (k < 83) return CTRL_A + lo;
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0100;
         1:       return 32'h0000_1000;
         2:       return 32'h0000_0FBC;
         3:       return 32'h0000_0FD0;
         4:       return 32'h8000_0FC4;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 64; i++) m_ram_ok[i] = 1'b0;
      m_ovf = 1'b0;
      m_cycle = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_data", out_data, 32'd0);
      a = STATUS_A; #1;
      check_eq("rst_status", rd, 32'h0000_0100);
      a = CYC_A; #1;
      check_eq("rst_cycle", rd, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      m_cycle = '0;

      // T1 RAM store/load and unmapped read
      step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
      check_eq("t1_ram", rd, 32'hDEAD_BEEF);
      a = 32'h1000; we = 1'b0; #1;
      check_eq("t1_unmapped", rd, 32'd0);
      step(1'b0, 32'h10, 32'h0, 1'b0);

      // T2 one-cycle TX latency
      step(1'b1, TX_A, 32'd1024, 1'b0);
      check_eq("t2_valid", 32'(out_valid), 32'd1);
      check_eq("t2_data", out_data, 32'd1024);
      a = STATUS_A; we = 1'b0; #1;
      check_eq("t2_status", rd, 32'h0000_0001);
      step(1'b0, STATUS_A, 32'h0, 1'b1);

      // T3 fill past full, then drain in order
      for (int i = 1; i <= 9; i++) step(1'b1, TX_A, 32'(i), 1'b0);
      a = STATUS_A; we = 1'b0; #1;
      check_eq("t3_status", rd, 32'h8000_0208);
      for (int i = 1; i <= 8; i++) begin
         check_eq("t3_drain", out_data, 32'(i));
         step(1'b0, STATUS_A, 32'h0, 1'b1);
      end
      check_eq("t3_empty", 32'(out_valid), 32'd0);

      // T5 CTRL clears ovf; a later overflow sets it again
      step(1'b1, CTRL_A, 32'd1, 1'b0);
      a = STATUS_A; we = 1'b0; #1;
      check_eq("t5_clear", 32'(rd[31]), 32'd0);
      for (int i = 0; i < 9; i++) step(1'b1, TX_A, 32'(200 + i), 1'b0);
      a = STATUS_A; we = 1'b0; #1;
      check_eq("t5_set", 32'(rd[31]), 32'd1);
      for (int i = 0; i < 8; i++) step(1'b0, CYC_A, 32'h0, 1'b1);
      step(1'b1, CTRL_A, 32'd1, 1'b1);

      // T4 push and pop together while full
      for (int i = 1; i <= 8; i++) step(1'b1, TX_A, 32'(100 + i), 1'b0);
      step(1'b1, TX_A, 32'd42, 1'b1);
      a = STATUS_A; we = 1'b0; #1;
      check_eq("t4_status", rd, 32'h0000_0208);
      for (int i = 0; i < 7; i++) step(1'b0, STATUS_A, 32'h0, 1'b1);
      check_eq("t4_last", out_data, 32'd42);
      step(1'b0, STATUS_A, 32'h0, 1'b1);

      // T6 reset mid-stream, then counter progression
      for (int i = 0; i < 3; i++) step(1'b1, TX_A, 32'(300 + i), 1'b0);
      we = 1'b0; a = STATUS_A;
      #2 reset = 1'b1;
      #1;
      check_eq("t6_valid", 32'(out_valid), 32'd0);
      check_eq("t6_status", rd, 32'h0000_0100);
      @(posedge clk); #1;
      reset = 1'b0;
      m_fifo.delete();
      m_ovf = 1'b0;
      m_cycle = '0;
      for (int i = 0; i < 6; i++) step(1'b0, CYC_A, 32'h0, 1'b0);

      // Randomized traffic with ready phases to exercise fill, overflow and drain
      for (int i = 0; i < 600; i++) begin
         logic        w;
         logic        r;
         logic [31:0] ad;
         case ((i / 25) % 3)
            0:       r = 1'b0;
            1:       r = ($urandom_range(0, 2) == 0);
            default: r = 1'b1;
         endcase
         w  = ($urandom_range(0, 9) < 7);
         ad = rand_addr();
         step(w, ad, $urandom, r);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
